// File: rtl/note_seq_pkg.sv
// note_seq_pkg
// Shared definitions for the note sequencer: FSM state encoding and the
// widths of the lane pattern, song ROM address and beat index.
package note_seq_pkg;

  localparam int LANE_W      = 4;   // lanes per beat pattern
  localparam int SONG_ADDR_W = 13;  // song ROM address width
  localparam int BEAT_IDX_W  = 8;   // beat index width (0..255)

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/note_sequencer_beat_timer.sv
// beat_timer
// Counts clock cycles within one beat. The count is cleared by clr_i,
// advances by one per cycle while en_i is high, and saturates at
// BEAT_CYCLES-1 so it can never leave its legal range.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   clr_i    - synchronous clear (wins over en_i)
//   en_i     - count enable (deasserted while playback is paused)
//   tc_o     - terminal count: count == BEAT_CYCLES-1
module beat_timer #(
  parameter  int BEAT_CYCLES = 12500000,
  localparam int CNT_W       = $clog2(BEAT_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc_o = (count_q == CNT_W'(BEAT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
// Steps through a song stored in an external ROM, one lane pattern per beat.
// Each beat runs FETCH (address presented) -> LATCH (ROM data arrives and is
// captured) -> HOLD (remaining cycles of the beat). After beat LAST_BEAT the
// FSM passes through DONE for one cycle and returns to IDLE.
// Ports:
//   clk         - clock, rising edge
//   reset_n     - asynchronous active-low reset
//   start       - begin playback from beat 0 (honoured only in IDLE)
//   stop        - abort playback, clears beat index and lanes
//   pause       - level; freezes FSM, timer, beat index and lanes
//   rom_addr    - song ROM address, {5'b0, beat_idx}
//   rom_data    - ROM lane pattern, valid one cycle after rom_addr
//   note_valid  - one-cycle pulse in the first HOLD cycle of each beat
//   note_lanes  - lane pattern of the current beat
//   beat_idx    - current beat index
//   busy        - high whenever not IDLE
//   done        - one-cycle pulse after the final beat
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int BEAT_CYCLES = 12500000,
  parameter int LAST_BEAT   = 231
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pause,
  output logic [SONG_ADDR_W-1:0] rom_addr,
  input  logic [LANE_W-1:0]      rom_data,
  output logic                   note_valid,
  output logic [LANE_W-1:0]      note_lanes,
  output logic [BEAT_IDX_W-1:0]  beat_idx,
  output logic                   busy,
  output logic                   done
);

  state_e                  state_q, state_d;
  logic [BEAT_IDX_W-1:0]   beat_idx_q, beat_idx_d;
  logic [LANE_W-1:0]       note_lanes_q, note_lanes_d;
  logic                    note_valid_q, note_valid_d;

  logic timer_clr;
  logic timer_en;
  logic timer_tc;
  logic in_play;
  logic last_beat;
  logic beat_end;

  assign in_play   = (state_q == ST_FETCH) || (state_q == ST_LATCH) ||
                     (state_q == ST_HOLD);
  assign last_beat = (beat_idx_q == BEAT_IDX_W'(LAST_BEAT));
  // Final cycle of an unpaused beat: the timer is at BEAT_CYCLES-1 in HOLD.
  assign beat_end  = (state_q == ST_HOLD) && !pause && timer_tc;

  // The timer is held at zero outside playback and restarted at every beat
  // boundary, so FETCH always sees 0 and LATCH sees 1.
  assign timer_clr = stop || !in_play || beat_end;
  assign timer_en  = in_play && !pause;

  beat_timer #(
    .BEAT_CYCLES (BEAT_CYCLES)
  ) u_beat_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (timer_clr),
    .en_i    (timer_en),
    .tc_o    (timer_tc)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stop beats pause, pause beats everything else.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (stop)        state_d = ST_IDLE;
        else if (!pause) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (stop)        state_d = ST_IDLE;
        else if (!pause) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (stop)          state_d = ST_IDLE;
        else if (beat_end) state_d = last_beat ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next-state
  always_comb begin
    beat_idx_d   = beat_idx_q;
    note_lanes_d = note_lanes_q;
    if (state_q != ST_IDLE && stop) begin
      beat_idx_d   = '0;
      note_lanes_d = '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        beat_idx_d = '0;
      end
      if (state_q == ST_LATCH && !pause) begin
        note_lanes_d = rom_data;
      end
      if (beat_end && !last_beat) begin
        beat_idx_d = beat_idx_q + BEAT_IDX_W'(1);
      end
    end
  end

  // The pulse is tied to the LATCH->HOLD transition, so it appears exactly
  // once per beat in the first HOLD cycle regardless of later pausing.
  assign note_valid_d = (state_q == ST_LATCH) && (state_d == ST_HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_idx_q   <= '0;
      note_lanes_q <= '0;
      note_valid_q <= 1'b0;
    end else begin
      beat_idx_q   <= beat_idx_d;
      note_lanes_q <= note_lanes_d;
      note_valid_q <= note_valid_d;
    end
  end

  // Output logic
  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    beat_idx   = beat_idx_q;
    note_lanes = note_lanes_q;
    note_valid = note_valid_q;
    rom_addr   = {{(SONG_ADDR_W - BEAT_IDX_W){1'b0}}, beat_idx_q};
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
// Directed bench for note_sequencer with BEAT_CYCLES = 4. One instance plays
// an 8-beat song (LAST_BEAT = 7), a second plays the full 256-beat range.
// Both use a 1-cycle registered ROM returning notes[i] = i[3:0].
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, pause;
  logic [12:0] rom_addr;
  logic [3:0]  rom_data;
  logic        note_valid;
  logic [3:0]  note_lanes;
  logic [7:0]  beat_idx;
  logic        busy, done;

  logic        start2, stop2, pause2;
  logic [12:0] rom_addr2;
  logic [3:0]  rom_data2;
  logic        note_valid2;
  logic [3:0]  note_lanes2;
  logic [7:0]  beat_idx2;
  logic        busy2, done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  note_sequencer #(.BEAT_CYCLES(4), .LAST_BEAT(7)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_valid(note_valid),
    .note_lanes(note_lanes), .beat_idx(beat_idx), .busy(busy), .done(done)
  );

  note_sequencer #(.BEAT_CYCLES(4), .LAST_BEAT(255)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .stop(stop2), .pause(pause2),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .note_valid(note_valid2),
    .note_lanes(note_lanes2), .beat_idx(beat_idx2), .busy(busy2), .done(done2)
  );

  // Song ROMs: registered read, notes[i] = i[3:0]
  always @(posedge clk) begin
    rom_data  <= rom_addr[3:0];
    rom_data2 <= rom_addr2[3:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full 8-beat playback from IDLE. Cycle 0 is the cycle carrying start.
  // Optionally re-pulses start during playback at cycle restart_at.
  task automatic play_check(input string tag, input int restart_at);
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      logic exp_nv;
      exp_nv = (c >= 3) && (c <= 31) && (((c - 3) % 4) == 0);
      check($sformatf("%s.busy.c%0d", tag, c), 32'(busy), 32'((c >= 1) && (c <= 33)));
      check($sformatf("%s.nv.c%0d", tag, c), 32'(note_valid), 32'(exp_nv));
      check($sformatf("%s.done.c%0d", tag, c), 32'(done), 32'(c == 33));
      if (c >= 1) begin
        check($sformatf("%s.beat.c%0d", tag, c), 32'(beat_idx),
              (c <= 32) ? 32'((c - 1) / 4) : 32'd7);
        check($sformatf("%s.addr.c%0d", tag, c), 32'(rom_addr),
              (c <= 32) ? 32'((c - 1) / 4) : 32'd7);
      end
      if (exp_nv) begin
        check($sformatf("%s.lanes.c%0d", tag, c), 32'(note_lanes), 32'((c - 3) / 4));
      end
      step();
      start = (c + 1 == restart_at);
    end
    check($sformatf("%s.lanes_kept", tag), 32'(note_lanes), 32'd7);
    $display("[TB] transaction %s: playback of 8 beats checked", tag);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 0; stop = 0; pause = 0;
    start2 = 0; stop2 = 0; pause2 = 0;

    // Reset state
    step();
    step();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.beat", 32'(beat_idx), 32'd0);
    check("rst.lanes", 32'(note_lanes), 32'd0);
    check("rst.nv", 32'(note_valid), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.addr", 32'(rom_addr), 32'd0);
    reset_n = 1'b1;
    step();
    $display("[TB] transaction reset: reset state checked");

    // Plain playback
    play_check("play", -1);
    step();

    // start re-pulsed mid playback is ignored
    play_check("restart", 5);
    step();

    // start and stop together in IDLE: stay IDLE
    start = 1; stop = 1;
    step();
    start = 0; stop = 0;
    check("startstop.busy", 32'(busy), 32'd0);
    step();
    check("startstop.busy2", 32'(busy), 32'd0);
    $display("[TB] transaction start+stop in IDLE checked");

    // pause high during cycles 3..8
    start = 1;
    for (int c = 0; c <= 16; c++) begin
      pause = (c >= 3) && (c <= 8);
      check($sformatf("pause.nv.c%0d", c), 32'(note_valid), 32'((c == 3) || (c == 13)));
      check($sformatf("pause.done.c%0d", c), 32'(done), 32'd0);
      if (c == 8) begin
        check("pause.frozen_beat", 32'(beat_idx), 32'd0);
        check("pause.frozen_lanes", 32'(note_lanes), 32'd0);
      end
      if (c == 13) begin
        check("pause.beat13", 32'(beat_idx), 32'd1);
        check("pause.lanes13", 32'(note_lanes), 32'd1);
      end
      step();
      start = 0;
    end
    pause = 0;
    stop = 1;
    step();
    stop = 0;
    check("pause.stopped", 32'(busy), 32'd0);
    $display("[TB] transaction pause cycles 3-8 checked");

    // stop at cycle 10
    start = 1;
    for (int c = 0; c <= 10; c++) begin
      stop = (c == 10);
      if (c == 7) check("stop.lanes7", 32'(note_lanes), 32'd1);
      if (c == 10) begin
        check("stop.busy10", 32'(busy), 32'd1);
        check("stop.beat10", 32'(beat_idx), 32'd2);
      end
      step();
      start = 0;
    end
    stop = 0;
    check("stop.busy11", 32'(busy), 32'd0);
    check("stop.beat11", 32'(beat_idx), 32'd0);
    check("stop.lanes11", 32'(note_lanes), 32'd0);
    check("stop.done11", 32'(done), 32'd0);
    for (int c = 12; c < 16; c++) begin
      check($sformatf("stop.nodone.c%0d", c), 32'(done), 32'd0);
      check($sformatf("stop.idle.c%0d", c), 32'(busy), 32'd0);
      step();
    end
    $display("[TB] transaction stop at cycle 10 checked");

    // reset asserted mid-beat at cycle 9
    start = 1;
    for (int c = 0; c < 9; c++) begin
      if (c == 7) check("rstmid.lanes7", 32'(note_lanes), 32'd1);
      step();
      start = 0;
    end
    check("rstmid.busy_before", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.beat", 32'(beat_idx), 32'd0);
    check("rstmid.lanes", 32'(note_lanes), 32'd0);
    check("rstmid.nv", 32'(note_valid), 32'd0);
    check("rstmid.done", 32'(done), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("rstmid.post_nv.%0d", c), 32'(note_valid), 32'd0);
      check($sformatf("rstmid.post_done.%0d", c), 32'(done), 32'd0);
      check($sformatf("rstmid.post_busy.%0d", c), 32'(busy), 32'd0);
      step();
    end
    $display("[TB] transaction reset mid-beat checked");
    play_check("replay", -1);

    // LAST_BEAT = 255 full run on the second instance
    begin
      bit seen_ff = 0;
      start2 = 1;
      for (int c = 0; c <= 1030; c++) begin
        if (rom_addr2 == 13'h0FF) seen_ff = 1;
        check($sformatf("lb255.done.c%0d", c), 32'(done2), 32'(c == 1025));
        if (c >= 1 && c <= 1024) begin
          check($sformatf("lb255.beat.c%0d", c), 32'(beat_idx2), 32'((c - 1) / 4));
        end
        if (c == 1025) begin
          check("lb255.beat_done", 32'(beat_idx2), 32'd255);
          check("lb255.addr_done", 32'(rom_addr2), 32'h0FF);
        end
        if (c == 1026) check("lb255.idle", 32'(busy2), 32'd0);
        step();
        start2 = 0;
      end
      check("lb255.seen_ff", 32'(seen_ff), 32'd1);
      check("lb255.beat_kept", 32'(beat_idx2), 32'd255);
      $display("[TB] transaction LAST_BEAT=255 playback checked");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter BEAT_CYCLES, default 12500000, clk cycles per beat (legal range >= 4).
REQ-002 Parameter LAST_BEAT, default 231, index of final playable beat (legal range 0..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin playback from beat 0; sampled per cycle.
REQ-006 stop  input  1  abort playback; sampled per cycle.
REQ-007 pause  input  1  level; while high, playback freezes.
REQ-008 rom_addr  output  13  song ROM read address; upper 5 bits always 0.
REQ-009 rom_data  input  4  song ROM lane pattern; valid one cycle after rom_addr is sampled.
REQ-010 note_valid  output  1  one-cycle pulse; note_lanes holds a new beat pattern.
REQ-011 note_lanes  output  4  registered lane pattern of current beat, bit i = lane i.
REQ-012 beat_idx  output  8  current beat index.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after final beat completes.

Function
REQ-015 FSM states: IDLE, FETCH, LATCH, HOLD, DONE.
REQ-016 rom_addr shall equal {5'b0, beat_idx} combinationally, at all times.
REQ-017 IDLE: on start=1 and stop=0, clear beat_idx and beat timer, next state FETCH; otherwise remain in IDLE.
REQ-018 FETCH: beat timer = 0; next state LATCH; ROM samples rom_addr at this edge.
REQ-019 LATCH: beat timer = 1; at the closing edge, capture rom_data into note_lanes; next state HOLD.
REQ-020 note_valid shall be high only in the first HOLD cycle of each beat (timer = 2), even for an all-zero pattern.
REQ-021 HOLD: the timer increments each cycle; when timer = BEAT_CYCLES-1, the FSM shall go to DONE if beat_idx = LAST_BEAT; otherwise it shall increment beat_idx and go to FETCH.
REQ-022 The beat period shall be exactly BEAT_CYCLES cycles, FETCH entry to FETCH entry, when unpaused.
REQ-023 beat_idx shall not wrap: LAST_BEAT = 255 ends in DONE, never at beat 0.
REQ-024 DONE shall last one cycle with done = 1, then go to IDLE; beat_idx and note_lanes shall keep their values.
REQ-025 pause = 1 in FETCH/LATCH/HOLD shall freeze state, timer, beat_idx and note_lanes; a pending note_valid pulse shall be delayed until the first unpaused HOLD cycle, and never duplicated.
REQ-026 stop = 1 in any non-IDLE state shall force IDLE next cycle and clear note_lanes, beat_idx and timer; done shall not pulse.
REQ-027 stop has priority over pause; pause has priority over start; start while busy is ignored.
REQ-028 start and stop both high in IDLE: remain IDLE.
REQ-029 The beat timer shall be ceil(log2(BEAT_CYCLES)) bits wide, unsigned, and shall never exceed BEAT_CYCLES-1.

Reset
REQ-030 reset_n = 0 shall immediately force IDLE, timer = 0, beat_idx = 0, note_lanes = 0, note_valid = 0, done = 0, busy = 0.
REQ-031 Reset asserted mid-beat shall discard the beat; after release, behaviour shall be as from power-up, with no spurious note_valid or done.

Structure
REQ-032 Package note_seq_pkg shall hold the state enum, LANE_W = 4, SONG_ADDR_W = 13 and BEAT_IDX_W = 8.
REQ-033 One sub-module, beat_timer, shall be used: a counter with clear, enable (not paused), terminal-count output and width derived from BEAT_CYCLES.

Verification (BEAT_CYCLES = 4, LAST_BEAT = 7, 1-cycle ROM model with notes[i] = i[3:0])
REQ-034 Start pulse at cycle 0 -> FETCH in cycle 1; note_valid in cycles 3, 7, 11, ..., 31 with note_lanes = 0..7; done in cycle 33; busy low from cycle 34.
REQ-035 pause high cycles 3-8 -> beat 0 note_valid once, in cycle 3; beat 1 note_valid in cycle 13; no duplicate pulses.
REQ-036 stop at cycle 10 -> IDLE in cycle 11, with beat_idx = 0, note_lanes = 0 and no done pulse.
REQ-037 start re-pulsed in cycle 5 during playback -> ignored; sequence identical to REQ-034.
REQ-038 reset_n low for 2 cycles at cycle 9 -> outputs 0 asynchronously; a later start replays from beat 0.
REQ-039 LAST_BEAT = 255 run -> rom_addr reaches 13'h0FF; done follows beat 255; beat_idx never returns to 0 during playback.
